btn_conditioner: RTL and testbench

BTN_CONDITIONER -- requirements
Module: btn_conditioner

---
 rtl/btn_conditioner.sv | 141 ++++++++++++++
 tb/tb_btn_conditioner.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/btn_conditioner.sv
// Button conditioner: 2-flop sync, per-channel tick debounce, edge pulses.
// Define BTN_AUTOREPEAT_EN to add hold-based auto-repeat on btn_press.
//
// Ports:
//   clk         - clock, all state on rising edge
//   rst_n       - asynchronous active-low reset
//   tick        - one-clk sample strobe; debounce/repeat advance on it
//   btn_in      - raw asynchronous buttons, active high
//   btn_level   - debounced button state
//   btn_press   - one-clk pulse per accepted press (or auto-repeat)
//   btn_release - one-clk pulse per accepted release
module btn_conditioner #(
    parameter int NUM_BTNS       = 6,
    parameter int DEBOUNCE_TICKS = 4,
    parameter int REPEAT_DELAY   = 30,
    parameter int REPEAT_RATE    = 6
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                tick,
    input  logic [NUM_BTNS-1:0] btn_in,
    output logic [NUM_BTNS-1:0] btn_level,
    output logic [NUM_BTNS-1:0] btn_press,
    output logic [NUM_BTNS-1:0] btn_release
);

    localparam int CW = $clog2(DEBOUNCE_TICKS + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_TICKS - 1);

    if (NUM_BTNS < 1 || NUM_BTNS > 16 ||
        DEBOUNCE_TICKS < 1 || DEBOUNCE_TICKS > 255 ||
        REPEAT_DELAY < 2 || REPEAT_DELAY > 1023 ||
        REPEAT_RATE < 1 || REPEAT_RATE > 1023) begin : g_bad_cfg
        $error("btn_conditioner: parameter out of range");
    end

    logic [NUM_BTNS-1:0]         sync1_q, sync2_q;
    logic [NUM_BTNS-1:0][CW-1:0] cnt_q, cnt_d;
    logic [NUM_BTNS-1:0]         level_q, level_d;
    logic [NUM_BTNS-1:0]         press_q, press_d;
    logic [NUM_BTNS-1:0]         release_q, release_d;
    logic [NUM_BTNS-1:0]         rise, fall;

    // A differing sample advances the count; a matching one (bounce)
    // restarts it. The last differing sample accepts the new level.
    always_comb begin
        cnt_d   = cnt_q;
        level_d = level_q;
        if (tick) begin
            for (int i = 0; i < NUM_BTNS; i++) begin
                if (sync2_q[i] == level_q[i]) begin
                    cnt_d[i] = '0;
                end else if (cnt_q[i] == CNT_LAST) begin
                    level_d[i] = sync2_q[i];
                    cnt_d[i]   = '0;
                end else begin
                    cnt_d[i] = cnt_q[i] + CW'(1);
                end
            end
        end
    end

    assign rise      = level_d & ~level_q;
    assign fall      = ~level_d & level_q;
    assign release_d = fall;

`ifdef BTN_AUTOREPEAT_EN
    localparam int HMAX = (REPEAT_DELAY > REPEAT_RATE) ?
                          REPEAT_DELAY : REPEAT_RATE;
    localparam int HW = $clog2(HMAX + 1);
    localparam logic [HW-1:0] DLY_LAST  = HW'(REPEAT_DELAY - 1);
    localparam logic [HW-1:0] RATE_LAST = HW'(REPEAT_RATE - 1);

    logic [NUM_BTNS-1:0][HW-1:0] hold_q, hold_d;
    logic [NUM_BTNS-1:0]         rep_q, rep_d;
    logic [NUM_BTNS-1:0]         rpt;

    // Hold only advances while the level stays high across the tick, so
    // the press tick and the release tick can never carry a repeat.
    // rep_q marks that the initial delay has elapsed and RATE now applies.
    always_comb begin
        hold_d = hold_q;
        rep_d  = rep_q;
        rpt    = '0;
        for (int i = 0; i < NUM_BTNS; i++) begin
            if (!level_q[i]) begin
                hold_d[i] = '0;
                rep_d[i]  = 1'b0;
            end else if (tick && level_d[i]) begin
                if (!rep_q[i] && hold_q[i] == DLY_LAST) begin
                    rpt[i]    = 1'b1;
                    hold_d[i] = '0;
                    rep_d[i]  = 1'b1;
                end else if (rep_q[i] && hold_q[i] == RATE_LAST) begin
                    rpt[i]    = 1'b1;
                    hold_d[i] = '0;
                end else begin
                    hold_d[i] = hold_q[i] + HW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_q <= '0;
            rep_q  <= '0;
        end else begin
            hold_q <= hold_d;
            rep_q  <= rep_d;
        end
    end

    assign press_d = rise | rpt;
`else
    assign press_d = rise;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            cnt_q     <= '0;
            level_q   <= '0;
            press_q   <= '0;
            release_q <= '0;
        end else begin
            sync1_q   <= btn_in;
            sync2_q   <= sync1_q;
            cnt_q     <= cnt_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

    assign btn_level   = level_q;
    assign btn_press   = press_q;
    assign btn_release = release_q;

endmodule

// File: tb/tb_btn_conditioner.sv
// Directed bench for btn_conditioner: debounce, pulses, repeat, reset.
// Expected repeat behaviour follows BTN_AUTOREPEAT_EN.
module tb_btn_conditioner;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       tick;
    logic [5:0] btn_in;
    logic [5:0] btn_level, btn_press, btn_release;
    logic       b1_in, b1_level, b1_press, b1_release;

    int checks   = 0;
    int failures = 0;
    int press_cnt[6] = '{default: 0};

`ifdef BTN_AUTOREPEAT_EN
    localparam bit AR = 1'b1;
`else
    localparam bit AR = 1'b0;
`endif

    always #5 clk = ~clk;

    btn_conditioner dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .tick        (tick),
        .btn_in      (btn_in),
        .btn_level   (btn_level),
        .btn_press   (btn_press),
        .btn_release (btn_release)
    );

    btn_conditioner #(.NUM_BTNS(1), .DEBOUNCE_TICKS(1)) u_dut1 (
        .clk         (clk),
        .rst_n       (rst_n),
        .tick        (tick),
        .btn_in      (b1_in),
        .btn_level   (b1_level),
        .btn_press   (b1_press),
        .btn_release (b1_release)
    );

    always @(negedge clk) begin
        for (int i = 0; i < 6; i++)
            if (btn_press[i]) press_cnt[i]++;
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Nine idle clocks then one tick clock; returns on the negedge
    // right after the tick edge, where its results are visible.
    task automatic step_tick();
        repeat (9) @(negedge clk);
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) step_tick();
    endtask

    logic [5:0] seq;

    initial begin
        rst_n  = 1'b0;
        tick   = 1'b0;
        btn_in = '0;
        b1_in  = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_out", {btn_level, btn_press, btn_release}, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // single clean press on channel 0
        btn_in[0] = 1'b1;
        ticks(3);
        check("t1_lvl3", btn_level, 6'h00);
        step_tick();
        check("t1_lvl4", btn_level, 6'h01);
        check("t1_press", btn_press, 6'h01);
        @(negedge clk);
        check("t1_press_1clk", btn_press, 6'h00);
        check("t1_cnt", press_cnt[0], 1);

        // bouncy input on channel 2: 1,0,1,1,1,1
        seq = 6'b111101;
        for (int k = 0; k < 6; k++) begin
            btn_in[2] = seq[k];
            step_tick();
            if (k == 4) check("t2_lvl_early", btn_level, 6'h01);
        end
        check("t2_lvl", btn_level, 6'h05);
        check("t2_press", btn_press, 6'h04);
        step_tick();
        check("t2_cnt", press_cnt[2], 1);

        // channels 1 and 4 released in the same cycle
        btn_in = btn_in | 6'h12;
        ticks(4);
        check("t3_lvl", btn_level, 6'h17);
        btn_in = btn_in & ~6'h12;
        ticks(3);
        check("t3_rel_early", btn_release, 6'h00);
        step_tick();
        check("t3_rel", btn_release, 6'h12);
        check("t3_nopress", btn_press, 6'h00);
        check("t3_lvl_after", btn_level, 6'h05);

        // single-tick debounce instance
        b1_in = 1'b1;
        step_tick();
        check("t4_lvl", b1_level, 1'b1);
        check("t4_press", b1_press, 1'b1);
        @(negedge clk);
        check("t4_press_1clk", b1_press, 1'b0);
        b1_in = 1'b0;
        step_tick();
        check("t4_rel", {b1_level, b1_release}, 2'b01);

        btn_in = '0;
        ticks(4);
        check("clr_lvl", btn_level, 6'h00);

        // long hold on channel 3
        btn_in[3] = 1'b1;
        ticks(4);
        check("t5_press0", btn_press, 6'h08);
        for (int k = 1; k <= 50; k++) begin
            step_tick();
            if (k == 29) check("t5_h29", btn_press[3], 1'b0);
            if (k == 30) check("t5_h30", btn_press[3], AR);
            if (k == 35) check("t5_h35", btn_press[3], 1'b0);
            if (k == 36) check("t5_h36", btn_press[3], AR);
            if (k == 48) check("t5_h48", btn_press[3], AR);
        end
        btn_in[3] = 1'b0;
        ticks(4);
        check("t5_rel", {btn_level, btn_release}, {6'h00, 6'h08});
        ticks(10);
        check("t5_cnt", press_cnt[3], AR ? 5 : 1);

        // reset pulse while held past the first repeat
        btn_in[3] = 1'b1;
        ticks(4);
        check("t6_press", btn_press, 6'h08);
        ticks(33);
        rst_n = 1'b0;
        @(negedge clk);
        check("t6_rst_out", {btn_level, btn_press, btn_release}, 0);
        @(negedge clk);
        check("t6_rst_b1", {b1_level, b1_press, b1_release}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        ticks(3);
        check("t6_lvl3", {btn_level, btn_press, btn_release}, 0);
        step_tick();
        check("t6_lvl4", btn_level, 6'h08);
        check("t6_press4", btn_press, 6'h08);
        btn_in = '0;
        ticks(4);
        check("t6_rel", btn_release, 6'h08);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
